// File: rtl/hid_report_writer_if.sv
// Write-request channel between the report writer and the backing memory.
// The writer drives the request; the memory returns a one-cycle acknowledge.
interface hid_report_writer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              bmem_wr_en;
    logic [DATA_W-1:0] bmem_wr_data;
    logic [ADDR_W-1:0] bmem_wr_addr;
    logic              bmem_resp;

    modport master (
        output bmem_wr_en,
        output bmem_wr_data,
        output bmem_wr_addr,
        input  bmem_resp
    );

    modport slave (
        input  bmem_wr_en,
        input  bmem_wr_data,
        input  bmem_wr_addr,
        output bmem_resp
    );
endinterface

// File: rtl/hid_report_writer.sv
// Periodic sample writer: latches per-channel samples and, on every timer
// tick, stores the serviced channels into per-channel ring regions in memory.
module hid_report_writer #(
    parameter int          DATA_W    = 64,
    parameter int          ADDR_W    = 32,
    parameter int          NUM_CH    = 2,
    parameter int          PERIOD    = 200000,
    parameter logic [63:0] BASE_ADDR = '0,
    parameter int          DEPTH     = 16,
    parameter int          MODE      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        data_valid,
    hid_report_writer_if.master      bmem,
    output logic                     busy,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              miss_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [DATA_W-1:0] latch [NUM_CH];
    logic [PTR_W-1:0]  ptr   [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_init;
    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] mask_left;
    logic [CH_W-1:0]   sel;
    logic              load;
    logic              issue;
    logic              ack;
    logic              miss_inc;
    logic [4:0]        n_drop;
    logic [16:0]       drop_sum;
    logic [ADDR_W-1:0] wr_addr_n;

    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;

    assign bmem.bmem_wr_en   = wr_en_q;
    assign bmem.bmem_wr_data = wr_data_q;
    assign bmem.bmem_wr_addr = wr_addr_q;

    assign tick = (cnt == CNT_W'(PERIOD - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    assign mask_init = (MODE == 1) ? {NUM_CH{1'b1}} : pending;
    assign sel_oh    = mask & (~mask + 1'b1);
    assign mask_left = mask & ~sel_oh;

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel = CH_W'(i);
            end
        end
    end

    assign wr_addr_n = ADDR_W'(BASE_ADDR)
                     + ((ADDR_W'(sel) * ADDR_W'(DEPTH)) + ADDR_W'(ptr[sel]))
                     * ADDR_W'(BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        issue    = 1'b0;
        ack      = 1'b0;
        miss_inc = tick && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (tick) begin
                    load = 1'b1;
                    if (|mask_init) begin
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                issue   = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (bmem.bmem_resp) begin
                    ack     = 1'b1;
                    state_n = (|mask_left) ? WRITE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Several channels may overwrite in the same cycle; each counts once.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_drop = n_drop + 5'(data_valid[i] & pending[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                latch[c] <= '0;
                ptr[c]   <= '0;
            end
            pending   <= '0;
            mask      <= '0;
            drop_cnt  <= '0;
            miss_cnt  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (data_valid[c]) begin
                    latch[c] <= data_i[c*DATA_W +: DATA_W];
                end
            end
            // A fresh sample arriving with the acknowledge keeps its flag.
            pending  <= (pending & ~(ack ? sel_oh : '0)) | data_valid;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (miss_inc && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (load) begin
                mask <= mask_init;
            end else if (ack) begin
                mask <= mask_left;
            end
            if (ack) begin
                ptr[sel] <= ptr[sel] + 1'b1;
                wr_en_q  <= 1'b0;
            end
            if (issue) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= latch[sel];
                wr_addr_q <= wr_addr_n;
            end
        end
    end

endmodule

// File: doc/hid_report_writer.md
HID_REPORT_WRITER -- requirements
Module: hid_report_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, sample/write data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent sample channels (1..8).
REQ-004 SHALL have parameter PERIOD, default 200000, timer period in clk cycles (>=2*NUM_CH+4).
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of channel 0 region.
REQ-006 SHALL have parameter DEPTH, default 16, words per channel ring region (power of two, >=2).
REQ-007 SHALL have parameter MODE, default 0; 0 = write only channels holding new data, 1 = write every channel every tick.
REQ-008 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have data_i  in  NUM_CH*DATA_W  channel samples, channel c at bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have data_valid  in  NUM_CH  per-channel one-cycle sample strobe.
REQ-011 SHALL have bmem_resp  in  1  memory write acknowledge.
REQ-012 SHALL have bmem_wr_en  out  1; bmem_wr_data  out  DATA_W; bmem_wr_addr  out  ADDR_W: memory write request.
REQ-013 SHALL have busy  out  1 (FSM not IDLE); drop_cnt  out  16 (overwritten samples); miss_cnt  out  16 (skipped ticks).

Function
REQ-014 SHALL on data_valid[c] capture data_i slice c into latch[c] and set pending[c].
REQ-015 SHALL, if pending[c] already set when data_valid[c] arrives, overwrite latch[c] and increment drop_cnt (saturate at 0xFFFF).
REQ-016 SHALL run a free-running counter 0..PERIOD-1, wrapping to 0; tick asserted for the one cycle counter==PERIOD-1.
REQ-017 SHALL implement FSM states IDLE, WRITE, WAIT.
REQ-018 SHALL in IDLE on tick load service mask = pending (MODE 0) or all ones (MODE 1); zero mask -> stay IDLE, else -> WRITE.
REQ-019 SHALL in WRITE select lowest-index set mask bit c, register bmem_wr_data=latch[c], bmem_wr_addr, assert bmem_wr_en next cycle, -> WAIT.
REQ-020 SHALL compute address = BASE_ADDR + (c*DEPTH + ptr[c])*(DATA_W/8), truncated to ADDR_W.
REQ-021 SHALL hold bmem_wr_en, bmem_wr_data, bmem_wr_addr stable in WAIT until bmem_resp sampled high.
REQ-022 SHALL on bmem_resp in WAIT: deassert bmem_wr_en next cycle, clear mask[c], increment ptr[c] (DEPTH-1 wraps to 0), clear pending[c]; -> WRITE if mask non-zero, else IDLE.
REQ-023 SHALL keep pending[c] set if data_valid[c] coincides with the bmem_resp clearing it (new data wins).
REQ-024 SHALL not alter bmem_wr_data when data_valid[c] arrives during WRITE/WAIT for channel c; only latch[c] updates.
REQ-025 SHALL ignore a tick arriving while busy and increment miss_cnt (saturate at 0xFFFF).
REQ-026 SHALL ignore bmem_resp in IDLE and WRITE.
REQ-027 SHALL give latency tick -> bmem_wr_en high of 2 cycles; resp -> next channel bmem_wr_en high of 2 cycles.
REQ-028 SHALL in MODE 1 write latch[c] even when pending[c] is clear (repeats last value; zero after reset).

Reset
REQ-029 SHALL on rst clear counter, FSM to IDLE, latches, pending, mask, ptr[] to 0, drop_cnt, miss_cnt to 0, bmem_wr_en/data/addr to 0, busy to 0.
REQ-030 SHALL on rst mid-WAIT drop bmem_wr_en next cycle and discard the outstanding write.

Verification
REQ-031 NUM_CH=2, PERIOD=16, MODE 0: data_valid[1] with 0xAA at cycle 3; resp 2 cycles after wr_en -> one write, data 0xAA, addr BASE_ADDR+DEPTH*8, pending[1] cleared.
REQ-032 Both channels valid before tick, resp immediate -> ch0 write at tick+2, ch1 at resp+2, addrs BASE_ADDR and BASE_ADDR+128 (DEPTH=16).
REQ-033 17 ticks with ch0 data each period -> ptr[0] wraps; 17th write addr = BASE_ADDR+0.
REQ-034 Two data_valid[0] before one tick -> drop_cnt=1, written data = second sample; resp withheld across next tick -> miss_cnt=1.
REQ-035 MODE 1, no data_valid after reset -> every tick writes 0 to both channels; zero mask never occurs.
REQ-036 rst asserted in WAIT -> bmem_wr_en 0 next cycle, all counters/pointers 0, later resp ignored.
